// File: rtl/apb_master_arbiter_m2_pkg.sv
// Shared types for the two-master APB arbiter: FSM states,
// grant encoding and response codes.
package apb_master_arbiter_m2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } state_e;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } grant_e;

    typedef enum logic [1:0] {
        RESP_OKAY,
        RESP_SLVERR,
        RESP_DECERR,
        RESP_TIMEOUT
    } resp_e;

    function automatic logic is_err(input resp_e resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_m2_addr_decoder4.sv
// Four-window APB address decoder: base/length match, lowest
// index wins. Purely combinational.
module apb_addr_decoder4 #(
    parameter int              AW    = 32,
    parameter logic [AW-1:0]   BASE0 = 'h0000_0000,
    parameter logic [AW-1:0]   BASE1 = 'h0001_0000,
    parameter logic [AW-1:0]   BASE2 = 'h0002_0000,
    parameter logic [AW-1:0]   BASE3 = 'h0003_0000,
    parameter int              PLEN0 = 16,
    parameter int              PLEN1 = 16,
    parameter int              PLEN2 = 16,
    parameter int              PLEN3 = 16
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [1:0]    idx
);

    localparam logic [AW-1:0] ONE   = 1;
    localparam logic [AW-1:0] MASK0 = ~((ONE << PLEN0) - ONE);
    localparam logic [AW-1:0] MASK1 = ~((ONE << PLEN1) - ONE);
    localparam logic [AW-1:0] MASK2 = ~((ONE << PLEN2) - ONE);
    localparam logic [AW-1:0] MASK3 = ~((ONE << PLEN3) - ONE);

    logic [3:0] match;

    assign match[0] = (addr & MASK0) == BASE0;
    assign match[1] = (addr & MASK1) == BASE1;
    assign match[2] = (addr & MASK2) == BASE2;
    assign match[3] = (addr & MASK3) == BASE3;
    assign hit      = |match;

    always_comb begin
        idx = 2'd0;
        priority case (1'b1)
            match[0]: idx = 2'd0;
            match[1]: idx = 2'd1;
            match[2]: idx = 2'd2;
            match[3]: idx = 2'd3;
            default:  idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/apb_master_arbiter_m2.sv
// Round-robin sharing of one APB master port between two
// request/done command masters, with optional PREADY timeout.
module apb_master_arbiter_m2
    import apb_master_arbiter_m2_pkg::*;
#(
    parameter int                     WIDTH_PAD     = 32,
    parameter int                     WIDTH_PDA     = 32,
    parameter logic [WIDTH_PAD-1:0]   ADDR_PBASE0   = 'h0000_0000,
    parameter logic [WIDTH_PAD-1:0]   ADDR_PBASE1   = 'h0001_0000,
    parameter logic [WIDTH_PAD-1:0]   ADDR_PBASE2   = 'h0002_0000,
    parameter logic [WIDTH_PAD-1:0]   ADDR_PBASE3   = 'h0003_0000,
    parameter int                     ADDR_PLENGTH0 = 16,
    parameter int                     ADDR_PLENGTH1 = 16,
    parameter int                     ADDR_PLENGTH2 = 16,
    parameter int                     ADDR_PLENGTH3 = 16,
    parameter int                     TIMEOUT       = 256,
    localparam int                    WIDTH_PDS     = WIDTH_PDA / 8
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 M0_REQ,
    input  logic [WIDTH_PAD-1:0] M0_ADDR,
    input  logic                 M0_WRITE,
    input  logic [WIDTH_PDA-1:0] M0_WDATA,
    input  logic [WIDTH_PDS-1:0] M0_STRB,
    output logic                 M0_DONE,
    output logic [WIDTH_PDA-1:0] M0_RDATA,
    output logic                 M0_ERR,
    input  logic                 M1_REQ,
    input  logic [WIDTH_PAD-1:0] M1_ADDR,
    input  logic                 M1_WRITE,
    input  logic [WIDTH_PDA-1:0] M1_WDATA,
    input  logic [WIDTH_PDS-1:0] M1_STRB,
    output logic                 M1_DONE,
    output logic [WIDTH_PDA-1:0] M1_RDATA,
    output logic                 M1_ERR,
    output logic [WIDTH_PAD-1:0] S_PADDR,
    output logic                 S_PWRITE,
    output logic [WIDTH_PDA-1:0] S_PWDATA,
    output logic [WIDTH_PDS-1:0] S_PSTRB,
    output logic                 S_PENABLE,
    output logic                 S0_PSEL,
    output logic                 S1_PSEL,
    output logic                 S2_PSEL,
    output logic                 S3_PSEL,
    input  logic [WIDTH_PDA-1:0] S0_PRDATA,
    input  logic [WIDTH_PDA-1:0] S1_PRDATA,
    input  logic [WIDTH_PDA-1:0] S2_PRDATA,
    input  logic [WIDTH_PDA-1:0] S3_PRDATA,
    input  logic                 S0_PREADY,
    input  logic                 S1_PREADY,
    input  logic                 S2_PREADY,
    input  logic                 S3_PREADY,
    input  logic                 S0_PSLVERR,
    input  logic                 S1_PSLVERR,
    input  logic                 S2_PSLVERR,
    input  logic                 S3_PSLVERR
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e               state_q, state_d;
    grant_e               gnt_q, gnt_d, last_q, last_d, sel;
    logic [WIDTH_PAD-1:0] addr_q, addr_d, sel_addr;
    logic                 write_q, write_d;
    logic [WIDTH_PDA-1:0] wdata_q, wdata_d;
    logic [WIDTH_PDS-1:0] strb_q, strb_d;
    logic [1:0]           idx_q, idx_d, dec_idx;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH_PDA-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                 err0_q, err0_d, err1_q, err1_d;
    logic                 dec_hit, tmo, bus_sel;
    logic                 rsp_ready, rsp_err;
    logic [WIDTH_PDA-1:0] rsp_data, fin_data;
    logic                 fin;
    resp_e                fin_resp;

    always_comb begin
        if (M0_REQ && M1_REQ)
            sel = (last_q == GNT_M0) ? GNT_M1 : GNT_M0;
        else
            sel = M1_REQ ? GNT_M1 : GNT_M0;
    end

    assign sel_addr = (sel == GNT_M1) ? M1_ADDR : M0_ADDR;

    apb_addr_decoder4 #(
        .AW    (WIDTH_PAD),
        .BASE0 (ADDR_PBASE0),
        .BASE1 (ADDR_PBASE1),
        .BASE2 (ADDR_PBASE2),
        .BASE3 (ADDR_PBASE3),
        .PLEN0 (ADDR_PLENGTH0),
        .PLEN1 (ADDR_PLENGTH1),
        .PLEN2 (ADDR_PLENGTH2),
        .PLEN3 (ADDR_PLENGTH3)
    ) u_dec (
        .addr (sel_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Only the selected slave's response is ever looked at.
    always_comb begin
        unique case (idx_q)
            2'd0: begin
                rsp_ready = S0_PREADY;
                rsp_err   = S0_PSLVERR;
                rsp_data  = S0_PRDATA;
            end
            2'd1: begin
                rsp_ready = S1_PREADY;
                rsp_err   = S1_PSLVERR;
                rsp_data  = S1_PRDATA;
            end
            2'd2: begin
                rsp_ready = S2_PREADY;
                rsp_err   = S2_PSLVERR;
                rsp_data  = S2_PRDATA;
            end
            default: begin
                rsp_ready = S3_PREADY;
                rsp_err   = S3_PSLVERR;
                rsp_data  = S3_PRDATA;
            end
        endcase
    end

    assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err0_d   = err0_q;
        err1_d   = err1_q;
        fin      = 1'b0;
        fin_resp = RESP_OKAY;
        fin_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (M0_REQ || M1_REQ) begin
                    gnt_d   = sel;
                    addr_d  = sel_addr;
                    write_d = (sel == GNT_M1) ? M1_WRITE : M0_WRITE;
                    wdata_d = (sel == GNT_M1) ? M1_WDATA : M0_WDATA;
                    strb_d  = (sel == GNT_M1) ? M1_STRB : M0_STRB;
                    idx_d   = dec_idx;
                    cnt_d   = '0;
                    if (dec_hit) begin
                        state_d = ST_SETUP;
                    end else begin
                        state_d  = ST_DONE;
                        fin      = 1'b1;
                        fin_resp = RESP_DECERR;
                    end
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (tmo) begin
                    state_d  = ST_DONE;
                    fin      = 1'b1;
                    fin_resp = RESP_TIMEOUT;
                end else if (rsp_ready) begin
                    state_d  = ST_DONE;
                    fin      = 1'b1;
                    fin_resp = rsp_err ? RESP_SLVERR : RESP_OKAY;
                    fin_data = write_q ? '0 : rsp_data;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end
        endcase
        // Results land in the per-master holding registers on entry to DONE.
        if (fin) begin
            if (gnt_d == GNT_M0) begin
                rdata0_d = fin_data;
                err0_d   = is_err(fin_resp);
            end else begin
                rdata1_d = fin_data;
                err1_d   = is_err(fin_resp);
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            gnt_q    <= GNT_M0;
            last_q   <= GNT_M1;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
        end
    end

    assign bus_sel   = (state_q == ST_SETUP) ||
                       ((state_q == ST_ACCESS) && !tmo);
    assign S_PENABLE = (state_q == ST_ACCESS) && !tmo;
    assign S0_PSEL   = bus_sel && (idx_q == 2'd0);
    assign S1_PSEL   = bus_sel && (idx_q == 2'd1);
    assign S2_PSEL   = bus_sel && (idx_q == 2'd2);
    assign S3_PSEL   = bus_sel && (idx_q == 2'd3);
    assign S_PADDR   = addr_q;
    assign S_PWRITE  = write_q;
    assign S_PWDATA  = wdata_q;
    assign S_PSTRB   = write_q ? strb_q : '0;

    assign M0_DONE   = (state_q == ST_DONE) && (gnt_q == GNT_M0);
    assign M1_DONE   = (state_q == ST_DONE) && (gnt_q == GNT_M1);
    assign M0_RDATA  = rdata0_q;
    assign M1_RDATA  = rdata1_q;
    assign M0_ERR    = err0_q;
    assign M1_ERR    = err1_q;

endmodule
